// File: rtl/updown_count_tracker.sv
// Observes an up/down counter's value and recovers its direction, flagging wraps,
// reversals, stalls and illegal steps; keeps a saturating count of illegal steps.
module updown_count_tracker #(
    parameter int WIDTH = 5,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    input  logic             sample,
    output logic             dir_up,
    output logic             dir_valid,
    output logic             wrap_up,
    output logic             wrap_down,
    output logic             reversal,
    output logic             stall,
    output logic             step_err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_ACQ  = 2'd1;
    localparam logic [1:0] ST_UP   = 2'd2;
    localparam logic [1:0] ST_DOWN = 2'd3;

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             dir_up_q, dir_up_d;
    logic             dir_valid_q, dir_valid_d;
    logic             wrap_up_q, wrap_up_d;
    logic             wrap_down_q, wrap_down_d;
    logic             reversal_q, reversal_d;
    logic             stall_q, stall_d;
    logic             step_err_q, step_err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] delta;

    // Modular difference: +1 and -1 wrap naturally at the counter boundary.
    assign delta = count_in - prev_q;

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        dir_up_d    = dir_up_q;
        dir_valid_d = dir_valid_q;
        err_cnt_d   = err_cnt_q;
        wrap_up_d   = 1'b0;
        wrap_down_d = 1'b0;
        reversal_d  = 1'b0;
        stall_d     = 1'b0;
        step_err_d  = 1'b0;

        if (sample) begin
            prev_d = count_in;
            if (state_q == ST_INIT) begin
                state_d = ST_ACQ;
            end else if (delta == CNT_ONE) begin
                state_d     = ST_UP;
                dir_up_d    = 1'b1;
                dir_valid_d = 1'b1;
                wrap_up_d   = (prev_q == CNT_MAX) && (count_in == '0);
                reversal_d  = (state_q == ST_DOWN);
            end else if (delta == CNT_MAX) begin
                state_d     = ST_DOWN;
                dir_up_d    = 1'b0;
                dir_valid_d = 1'b1;
                wrap_down_d = (prev_q == '0) && (count_in == CNT_MAX);
                reversal_d  = (state_q == ST_UP);
            end else if (delta == '0) begin
                stall_d = 1'b1;
            end else begin
                // Illegal step: drop back to acquisition but keep the last known direction.
                step_err_d  = 1'b1;
                state_d     = ST_ACQ;
                dir_valid_d = 1'b0;
                if (err_cnt_q != ERR_MAX) begin
                    err_cnt_d = err_cnt_q + ERR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            prev_q      <= '0;
            dir_up_q    <= 1'b0;
            dir_valid_q <= 1'b0;
            wrap_up_q   <= 1'b0;
            wrap_down_q <= 1'b0;
            reversal_q  <= 1'b0;
            stall_q     <= 1'b0;
            step_err_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            dir_up_q    <= dir_up_d;
            dir_valid_q <= dir_valid_d;
            wrap_up_q   <= wrap_up_d;
            wrap_down_q <= wrap_down_d;
            reversal_q  <= reversal_d;
            stall_q     <= stall_d;
            step_err_q  <= step_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign dir_up    = dir_up_q;
    assign dir_valid = dir_valid_q;
    assign wrap_up   = wrap_up_q;
    assign wrap_down = wrap_down_q;
    assign reversal  = reversal_q;
    assign stall     = stall_q;
    assign step_err  = step_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_updown_count_tracker.sv
// Directed, table-driven bench for updown_count_tracker (WIDTH=5, ERR_W=8).
module tb_updown_count_tracker;

    logic       clk;
    logic       reset;
    logic [4:0] count_in;
    logic       sample;
    logic       dir_up, dir_valid, wrap_up, wrap_down, reversal, stall, step_err;
    logic [7:0] err_cnt;

    updown_count_tracker #(.WIDTH(5), .ERR_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .count_in  (count_in),
        .sample    (sample),
        .dir_up    (dir_up),
        .dir_valid (dir_valid),
        .wrap_up   (wrap_up),
        .wrap_down (wrap_down),
        .reversal  (reversal),
        .stall     (stall),
        .step_err  (step_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       smp;
        logic [4:0] cnt;
        logic       up;
        logic       vld;
        logic       wu;
        logic       wd;
        logic       rev;
        logic       stl;
        logic       serr;
        logic [7:0] err;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic void add(input string name, input logic rst, input logic smp,
                                input logic [4:0] cnt, input logic up, input logic vld,
                                input logic wu, input logic wd, input logic rev,
                                input logic stl, input logic serr, input logic [7:0] err);
        vec_t v;
        v.name = name; v.rst = rst; v.smp = smp; v.cnt = cnt;
        v.up = up; v.vld = vld; v.wu = wu; v.wd = wd; v.rev = rev;
        v.stl = stl; v.serr = serr; v.err = err;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v);
        logic [14:0] act, exp;
        @(negedge clk);
        reset    = v.rst;
        sample   = v.smp;
        count_in = v.cnt;
        @(posedge clk);
        #1;
        act = {dir_up, dir_valid, wrap_up, wrap_down, reversal, stall, step_err, err_cnt};
        exp = {v.up, v.vld, v.wu, v.wd, v.rev, v.stl, v.serr, v.err};
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got up/vld/wu/wd/rev/stl/serr=%b err=%0d, want %b err=%0d",
                     v.name, act[14:8], act[7:0], exp[14:8], exp[7:0]);
        end
    endtask

    initial begin
        logic [4:0] c;
        vec_t       v;

        reset    = 1'b1;
        sample   = 1'b0;
        count_in = '0;

        // Reset 2 cycles, then 3 idle cycles.
        add("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 0..31,0,1: first sample only acquires; wrap_up on 31->0.
        for (int i = 0; i < 34; i++) begin
            c = 5'(i);
            if (i == 0) add("up_acq", 0, 1, c, 0, 0, 0, 0, 0, 0, 0, 0);
            else        add("up_run", 0, 1, c, 1, 1, (i == 32), 0, 0, 0, 0, 0);
        end

        // Continue up to 21, then reverse down.
        for (int i = 2; i <= 21; i++) add("up_to21", 0, 1, 5'(i), 1, 1, 0, 0, 0, 0, 0, 0);
        add("rev_20", 0, 1, 20, 0, 1, 0, 0, 1, 0, 0, 0);
        add("dn_19",  0, 1, 19, 0, 1, 0, 0, 0, 0, 0, 0);
        add("dn_18",  0, 1, 18, 0, 1, 0, 0, 0, 0, 0, 0);

        // Fresh down-count through 0 -> 31.
        add("rst_a",   1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        add("dn_acq3", 0, 1, 3,  0, 0, 0, 0, 0, 0, 0, 0);
        add("dn_2",    0, 1, 2,  0, 1, 0, 0, 0, 0, 0, 0);
        add("dn_1",    0, 1, 1,  0, 1, 0, 0, 0, 0, 0, 0);
        add("dn_0",    0, 1, 0,  0, 1, 0, 0, 0, 0, 0, 0);
        add("wrap_dn", 0, 1, 31, 0, 1, 0, 1, 0, 0, 0, 0);
        add("dn_30",   0, 1, 30, 0, 1, 0, 0, 0, 0, 0, 0);

        // 5,6,6,9,10: stall, illegal step, recovery without reversal.
        add("rst_b",   1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        add("s_acq5",  0, 1, 5,  0, 0, 0, 0, 0, 0, 0, 0);
        add("s_6",     0, 1, 6,  1, 1, 0, 0, 0, 0, 0, 0);
        add("stall_6", 0, 1, 6,  1, 1, 0, 0, 0, 1, 0, 0);
        add("err_9",   0, 1, 9,  1, 0, 0, 0, 0, 0, 1, 1);
        add("rec_10",  0, 1, 10, 1, 1, 0, 0, 0, 0, 0, 1);
        add("hold",    0, 0, 25, 1, 1, 0, 0, 0, 0, 0, 1);
        add("up_11",   0, 1, 11, 1, 1, 0, 0, 0, 0, 0, 1);
        add("up_12",   0, 1, 12, 1, 1, 0, 0, 0, 0, 0, 1);

        // Reset coincident with sample: reset wins, next sample only acquires.
        add("rst_smp", 1, 1, 13, 0, 0, 0, 0, 0, 0, 0, 0);
        add("post_acq", 0, 1, 14, 0, 0, 0, 0, 0, 0, 0, 0);
        add("post_up", 0, 1, 15, 1, 1, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) apply(vecs[i]);

        // 300 illegal +2 steps from prev=15: err_cnt saturates at 255.
        c = 5'd15;
        for (int k = 1; k <= 300; k++) begin
            c = c + 5'd2;
            v.name = "sat"; v.rst = 0; v.smp = 1; v.cnt = c;
            v.up = 1; v.vld = 0; v.wu = 0; v.wd = 0; v.rev = 0; v.stl = 0; v.serr = 1;
            v.err = (k > 255) ? 8'd255 : 8'(k);
            apply(v);
        end
        v.name = "sat_idle"; v.smp = 0; v.serr = 0; v.err = 8'd255;
        apply(v);
        v.name = "sat_rst"; v.rst = 1; v.up = 0; v.err = 8'd0;
        apply(v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
